// File: rtl/frame_io_pkg.sv
// Shared definitions for the frame I/O DMA and the pixel renderer:
// FSM encoding, default addresses and the object-table layout.
package frame_io_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WRITE_IN = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_COMMIT   = 3'd4;

  typedef enum logic [2:0] {
    StIdle    = S_IDLE,
    StWriteIn = S_WRITE_IN,
    StRead    = S_READ,
    StDrain   = S_DRAIN,
    StCommit  = S_COMMIT
  } dma_state_e;

  localparam logic [15:0] DEF_BASE_ADDR  = 16'hFF00;
  localparam logic [15:0] DEF_INPUT_ADDR = 16'hFEFF;
  localparam int unsigned DEF_NUM_WORDS  = 6;

  // Object-table word indices, shared with the renderer.
  localparam int unsigned IDX_PADL_Y  = 0;
  localparam int unsigned IDX_PADR_Y  = 1;
  localparam int unsigned IDX_BALL_X  = 2;
  localparam int unsigned IDX_BALL_Y  = 3;
  localparam int unsigned IDX_SCORE_L = 4;
  localparam int unsigned IDX_SCORE_R = 5;

  function automatic logic [15:0] btn_word(input logic [3:0] btn);
    return {12'b0, btn};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_d, meta_q;
  logic [Width-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/frame_io_dma.sv
// Per-frame BRAM port-B engine: posts the button word to the input mailbox on vblank,
// burst-reads the object table and commits it to the renderer as one atomic bundle.
module frame_io_dma
  import frame_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
  parameter logic [15:0] INPUT_ADDR = DEF_INPUT_ADDR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vblank_start,
  input  logic [3:0]              buttons,
  input  logic [15:0]             q_b,
  output logic [15:0]             addr_b,
  output logic [15:0]             data_b,
  output logic                    we_b,
  output logic [16*NUM_WORDS-1:0] obj_words,
  output logic                    frame_valid,
  output logic                    busy,
  output logic                    overrun
);

  if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : gen_bad_num_words
    $error("frame_io_dma: NUM_WORDS must be in 1..16");
  end

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  typedef logic [NUM_WORDS-1:0][15:0] table_t;

  dma_state_e      state_d, state_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic [15:0]     addr_d, addr_q;
  logic [15:0]     data_d, data_q;
  logic            we_d, we_q;
  logic            fv_d, fv_q;
  table_t          shadow_d, shadow_q;
  table_t          obj_d, obj_q;
  logic [3:0]      btn_sync;

  sync_2ff #(
    .Width (4)
  ) u_btn_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (buttons),
    .q_o    (btn_sync)
  );

  // Port-B outputs are registered, so they are computed from the state being entered.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    fv_d     = 1'b0;
    shadow_d = shadow_q;
    obj_d    = obj_q;

    unique case (state_q)
      StIdle: begin
        if (vblank_start) begin
          state_d = StWriteIn;
          addr_d  = INPUT_ADDR;
          data_d  = btn_word(btn_sync);
          we_d    = 1'b1;
        end
      end
      StWriteIn: begin
        state_d = StRead;
        idx_d   = '0;
        addr_d  = BASE_ADDR;
      end
      StRead: begin
        // q_b lags addr_b by one cycle, so it belongs to the previous index.
        if (idx_q != '0) begin
          shadow_d[idx_q - 1'b1] = q_b;
        end
        if (idx_q == LastIdx) begin
          state_d = StDrain;
        end else begin
          idx_d  = idx_q + 1'b1;
          addr_d = BASE_ADDR + 16'(idx_q) + 16'd1;
        end
      end
      StDrain: begin
        shadow_d[LastIdx] = q_b;
        // Whole table lands on one edge together with the frame_valid pulse.
        obj_d   = shadow_d;
        fv_d    = 1'b1;
        state_d = StCommit;
      end
      StCommit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      fv_q     <= 1'b0;
      shadow_q <= '0;
      obj_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      fv_q     <= fv_d;
      shadow_q <= shadow_d;
      obj_q    <= obj_d;
    end
  end

  assign addr_b      = addr_q;
  assign data_b      = data_q;
  assign we_b        = we_q;
  assign obj_words   = obj_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = vblank_start & busy;

endmodule

// File: doc/frame_io_dma.md
Name: frame_io_dma

Overview:
- Downstream/peripheral stage on the CPU's unused BRAM port B (addr_b, data_b, we_b, q_b).
- Once per video frame, on a vblank_start pulse, it writes the synchronized controller button word into a fixed input mailbox address.
- It then burst-reads the game-object table (paddles, ball, scores) the CPU program maintains.
- It presents those values as an atomically-updated, frame-stable bundle to the pixel renderer, so the renderer never sees a half-written frame.

Parameters:
- BASE_ADDR, 16'hFF00, first BRAM word of the object table.
- NUM_WORDS, 6, number of table words fetched per frame; legal range 1..16.
- INPUT_ADDR, 16'hFEFF, BRAM word receiving the button state.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- vblank_start  input  1  one-cycle pulse from video timing at start of vertical blank.
- buttons  input  4  raw asynchronous pushbuttons {R_dn, R_up, L_dn, L_up}.
- q_b  input  16  BRAM port B read data; valid the cycle after addr_b is presented.
- addr_b  output  16  BRAM port B address.
- data_b  output  16  BRAM port B write data.
- we_b  output  1  BRAM port B write enable.
- obj_words  output  16*NUM_WORDS  committed table; word i occupies bits [16*i+15:16*i].
- frame_valid  output  1  one-cycle pulse when obj_words has just been updated.
- busy  output  1  high whenever FSM is not IDLE.
- overrun  output  1  one-cycle pulse when vblank_start arrives while busy.

Behaviour:
- Reset (reset==0, asynchronous):
  - FSM goes to IDLE.
  - addr_b, data_b, obj_words, shadow registers, read index and synchronizer flops all clear to 0.
  - we_b, frame_valid, busy and overrun clear to 0.
- Button synchronizer: 2-flop chain per bit. btn_sync is the second flop. Write word = {12'b0, btn_sync}.
- FSM states: IDLE, WRITE_IN, READ, DRAIN, COMMIT.
- IDLE:
  - we_b=0.
  - If vblank_start=1, go to WRITE_IN next cycle.
- WRITE_IN (1 cycle):
  - addr_b=INPUT_ADDR, data_b={12'b0,btn_sync}, we_b=1.
  - Clear idx to 0, then go to READ.
- READ (NUM_WORDS cycles):
  - we_b=0, addr_b=BASE_ADDR+idx, where the sum is 16-bit modulo, so the table may wrap past 16'hFFFF to 16'h0000.
  - From the second READ cycle on, capture q_b into shadow[idx-1].
  - idx increments each cycle. After issuing idx=NUM_WORDS-1, go to DRAIN.
- DRAIN (1 cycle): capture q_b into shadow[NUM_WORDS-1].
- COMMIT (1 cycle):
  - obj_words <= shadow in a single register update; frame_valid=1 this cycle only.
  - Return to IDLE.
- Latency: vblank_start seen in cycle 0 gives frame_valid high in cycle NUM_WORDS+3. busy is high in cycles 1..NUM_WORDS+3.
- obj_words is stable except on the COMMIT edge. It is never partially updated.
- data_b holds its last written value while we_b=0. Only we_b qualifies writes.
- vblank_start while busy: ignored (no restart, no queueing), overrun pulses for 1 cycle.
- vblank_start in the COMMIT cycle counts as busy, so it is ignored and flagged.
- Reset mid-burst: immediate abort. obj_words returns to 0. No COMMIT or frame_valid for the aborted frame.
- CPU port-A accesses to the same address in the same cycle follow BRAM dual-port semantics. Software writes the table outside vblank; the block does not arbitrate.
- NUM_WORDS outside 1..16: elaboration-time error.

Decomposition:
- Shared package frame_io_pkg:
  - FSM state encoding (3-bit localparams S_IDLE..S_COMMIT).
  - Default BASE_ADDR, INPUT_ADDR and the object-table index constants: IDX_PADL_Y=0, IDX_PADR_Y=1, IDX_BALL_X=2, IDX_BALL_Y=3, IDX_SCORE_L=4, IDX_SCORE_R=5. The renderer shares these.
- One natural sub-module, sync_2ff: parameterised-width two-flop synchronizer with async active-low reset, reused for the buttons.
- The BRAM model is the existing memory; the bench instantiates it.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset=0 for 3 cycles, release, no vblank.
  - Required: all outputs 0, we_b never 1.
- Basic frame:
  - Stimulus: preload BRAM FF00..FF05 = 0010,0020,0140,00F0,0003,0007; buttons=4'b0101 stable for more than 2 cycles; pulse vblank_start at cycle 0.
  - Required: cycle 1 we_b=1, addr_b=FEFF, data_b=0005; cycles 2..7 addr_b=FF00..FF05.
  - Required: frame_valid at cycle 9 only, obj_words = {0007,0003,00F0,0140,0020,0010}; BRAM[FEFF]=0005.
- Atomicity:
  - Stimulus: after one frame, change BRAM table contents and start a second vblank.
  - Required: obj_words holds the old values through cycle 8 and switches to the new values exactly at the cycle-9 edge.
- Overrun:
  - Stimulus: pulse vblank_start at cycles 0 and 4.
  - Required: overrun=1 at cycle 4 only; a single frame_valid at cycle 9; no second burst.
- Wrap-around:
  - Stimulus: BASE_ADDR=FFFE, NUM_WORDS=4.
  - Required: addr_b sequence FFFE,FFFF,0000,0001; words captured in that order.
- Reset mid-burst:
  - Stimulus: assert reset=0 asynchronously at cycle 5 of a frame, then release.
  - Required: outputs immediately 0, no frame_valid. The next vblank performs a complete normal frame.
